vga_pixel_out: RTL and testbench

//  Consumer end of the drawer bus: generates VGA scan timing, presents the current pixel

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_scan_counter.sv | 60 ++++++
 rtl/vga_pixel_out.sv | 99 +++++++++
 tb/tb_vga_pixel_out.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants, colour format and shared scan types
// for the VGA pixel output stage.
package vga_pkg;

    // Horizontal timing, in pixels
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    // Vertical timing, in lines
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Clock cycles per pixel and drawer-path latency in pixel ticks
    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_PIPE_LAT = 2;

    // Colour format RRGGBB, 2 bits per channel
    localparam int unsigned DEF_COLOR_W  = 6;
    localparam int unsigned R_HI = 5;
    localparam int unsigned R_LO = 4;
    localparam int unsigned G_HI = 3;
    localparam int unsigned G_LO = 2;
    localparam int unsigned B_HI = 1;
    localparam int unsigned B_LO = 0;

    localparam logic [DEF_COLOR_W-1:0] DEF_BG_COLOR = 6'h00;
    localparam logic                   DEF_SYNC_POL = 1'b0;

    // Per-pixel decode carried down the delay line
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } scan_flags_t;

    // True when lo <= pos < lo+len
    function automatic logic in_window(input logic [9:0] pos,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (pos >= 10'(lo)) && (pos < 10'(lo + len));
    endfunction

endpackage

// File: rtl/vga_scan_counter.sv
// Pixel-clock divider and raster position counters. pix_tick and
// frame_start are registered so they are clean one-cycle strobes.
module vga_scan_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [9:0] px,
    output logic [9:0] py,
    output logic       pix_tick,
    output logic       frame_start
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

    logic [3:0] div;
    logic [3:0] div_next;

    // Next divider value, wrapping at CLK_DIV-1
    always_comb begin
        div_next = (div == DIV_LAST) ? '0 : div + 4'd1;
    end

    // Divider, tick strobe and raster counters; the tick is registered from
    // div_next so it is high exactly while div == CLK_DIV-1 (always, once
    // out of reset, when CLK_DIV is 1)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div         <= '0;
            pix_tick    <= 1'b0;
            px          <= '0;
            py          <= '0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_next;
            pix_tick    <= (div_next == DIV_LAST);
            frame_start <= 1'b0;
            if (pix_tick) begin
                if (px == H_LAST) begin
                    px <= '0;
                    if (py == V_LAST) begin
                        py          <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        py <= py + 10'd1;
                    end
                end else begin
                    px <= px + 10'd1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_pixel_out.sv
// VGA output stage: scan timing to the drawers, blanking/sync decode
// delayed to match the drawer latency, and registered colour/sync pins.
module vga_pixel_out
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
    parameter int unsigned COLOR_W  = DEF_COLOR_W,
    parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(DEF_BG_COLOR),
    parameter logic        SYNC_POL = DEF_SYNC_POL
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               draw,
    input  logic [COLOR_W-1:0] data,
    output logic [9:0]         px,
    output logic [9:0]         py,
    output logic               pix_tick,
    output logic               frame_start,
    output logic [COLOR_W-1:0] rgb,
    output logic               hsync,
    output logic               vsync
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_pixel_out: H_TOTAL/V_TOTAL exceed 10-bit scan counters");
    end
    if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
        $error("vga_pixel_out: CLK_DIV must be 1..8");
    end
    if (PIPE_LAT < 1 || PIPE_LAT > 4) begin : g_bad_lat
        $error("vga_pixel_out: PIPE_LAT must be 1..4");
    end

    vga_scan_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .CLK_DIV (CLK_DIV)
    ) u_scan (
        .clk         (clk),
        .reset_n     (reset_n),
        .px          (px),
        .py          (py),
        .pix_tick    (pix_tick),
        .frame_start (frame_start)
    );

    scan_flags_t cur;
    scan_flags_t dl [PIPE_LAT];
    scan_flags_t tail;

    // Blanking and sync decode of the pixel currently presented to the drawers
    always_comb begin
        cur.act = (px < 10'(H_ACTIVE)) && (py < 10'(V_ACTIVE));
        cur.hs  = in_window(px, H_ACTIVE + H_FP, H_SYNC);
        cur.vs  = in_window(py, V_ACTIVE + V_FP, V_SYNC);
        tail    = dl[PIPE_LAT-1];
    end

    // Delay line: the oldest entry belongs to the pixel whose draw/data is on
    // the bus now, PIPE_LAT ticks after its coordinates were presented
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                dl[i] <= '0;
            end
        end else if (pix_tick) begin
            dl[0] <= cur;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    // Output pins, updated together once per pixel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb   <= '0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else if (pix_tick) begin
            rgb   <= !tail.act ? '0 : (draw ? data : BG_COLOR);
            hsync <= tail.hs ? SYNC_POL : ~SYNC_POL;
            vsync <= tail.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_pixel_out.sv
// Randomized self-checking bench for vga_pixel_out on a small 14x8 raster.
module tb_vga_pixel_out;

    localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 1, HT = 14;
    localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1, VT = 8;
    localparam int unsigned DIV = 2, LAT = 2, FRAME = HT * VT;
    localparam logic [5:0]  BG = 6'h15;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       draw = 1'b0;
    logic [5:0] data = 6'h00;
    logic [9:0] px, py;
    logic       pix_tick, frame_start, hsync, vsync;
    logic [5:0] rgb;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    vga_pixel_out #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .CLK_DIV  (DIV), .PIPE_LAT (LAT), .COLOR_W (6),
        .BG_COLOR (BG), .SYNC_POL (1'b0)
    ) dut (
        .clk (clk), .reset_n (reset_n), .draw (draw), .data (data),
        .px (px), .py (py), .pix_tick (pix_tick), .frame_start (frame_start),
        .rgb (rgb), .hsync (hsync), .vsync (vsync)
    );

    always #5 clk = ~clk;

    // Reference: raster position follows from the clock count since reset;
    // the pins show pixel number (ticks - LAT) in raster order
    int unsigned m_c   = 0;
    logic [7:0]  m_out = 8'hC0;   // {hsync, vsync, rgb}

    function automatic logic [21:0] exp_timing(input int unsigned c);
        int unsigned n = c / DIV;
        logic [9:0] x  = 10'(n % HT);
        logic [9:0] y  = 10'((n / HT) % VT);
        logic t  = (c % DIV) == DIV - 1;
        logic fs = (c > 0) && (c % DIV == 0) && (n % FRAME == 0);
        return {x, y, t, fs};
    endfunction

    function automatic logic [7:0] exp_out(input int unsigned n, input logic d, input logic [5:0] dat);
        int unsigned idx, x, y;
        logic act, hs, vs;
        if (n < LAT) return 8'hC0;
        idx = (n - LAT) % FRAME;
        x   = idx % HT;
        y   = idx / HT;
        act = (x < HA) && (y < VA);
        hs  = (x >= HA + HF) && (x < HA + HF + HS);
        vs  = (y >= VA + VF) && (y < VA + VF + VS);
        return {~hs, ~vs, act ? (d ? dat : BG) : 6'h00};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_c   <= 0;
            m_out <= 8'hC0;
        end else begin
            m_c <= m_c + 1;
            if (m_c % DIV == DIV - 1)
                m_out <= exp_out(m_c / DIV, draw, data);
        end
    end

    task automatic wait_frame_align();
        for (int i = 0; i < int'(FRAME * DIV) && (m_c % (FRAME * DIV)) != 0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({px, py, pix_tick, frame_start, rgb, hsync, vsync} !== {10'd0, 10'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1}) begin
                miscompares++;
                $display("FAIL reset: got px=%0d py=%0d tick=%b fs=%b rgb=%h hs=%b vs=%b, want all zero with syncs 1",
                         px, py, pix_tick, frame_start, rgb, hsync, vsync);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_scan();
        int unsigned fs_cnt;
        draw = 1'b0;
        for (int w = 0; w < 2; w++) begin
            fs_cnt = 0;
            for (int i = 0; i < int'(FRAME * DIV); i++) begin
                @(negedge clk);
                vectors++;
                if ({px, py, pix_tick, frame_start} !== exp_timing(m_c)) begin
                    miscompares++;
                    $display("FAIL scan c=%0d: got px=%0d py=%0d tick=%b fs=%b, want %h",
                             m_c, px, py, pix_tick, frame_start, exp_timing(m_c));
                end
                if (frame_start) fs_cnt++;
            end
            vectors++;
            if (fs_cnt != 1) begin
                miscompares++;
                $display("FAIL frame_start_rate: got %0d pulses in %0d clks, want 1", fs_cnt, FRAME * DIV);
            end
        end
    endtask

    task automatic test_background();
        int unsigned bg_cnt = 0, hs_cnt = 0, vs_cnt = 0;
        draw = 1'b0;
        wait_frame_align();
        for (int i = 0; i < int'(FRAME * DIV); i++) begin
            @(negedge clk);
            vectors++;
            if ({hsync, vsync, rgb} !== m_out) begin
                miscompares++;
                $display("FAIL background c=%0d: got hs=%b vs=%b rgb=%h, want %h", m_c, hsync, vsync, rgb, m_out);
            end
            if (m_c % DIV == 0) begin
                if (rgb == BG) bg_cnt++;
                if (!hsync) hs_cnt++;
                if (!vsync) vs_cnt++;
            end
            data = 6'($urandom);
        end
        vectors += 3;
        if (bg_cnt != HA * VA) begin
            miscompares++;
            $display("FAIL bg_pixels: got %0d, want %0d", bg_cnt, HA * VA);
        end
        if (hs_cnt != HS * VT) begin
            miscompares++;
            $display("FAIL hsync_low_pixels: got %0d, want %0d", hs_cnt, HS * VT);
        end
        if (vs_cnt != VS * HT) begin
            miscompares++;
            $display("FAIL vsync_low_pixels: got %0d, want %0d", vs_cnt, VS * HT);
        end
    endtask

    task automatic test_single_pixel();
        int unsigned hit = 0;
        logic [21:0] t;
        wait_frame_align();
        for (int i = 0; i < int'(FRAME * DIV); i++) begin
            t    = exp_timing(m_c);
            draw = (t[21:12] == 10'd3);
            data = draw ? 6'h2A : 6'($urandom);
            @(negedge clk);
            vectors++;
            if ({hsync, vsync, rgb} !== m_out) begin
                miscompares++;
                $display("FAIL single_pixel c=%0d: got hs=%b vs=%b rgb=%h, want %h", m_c, hsync, vsync, rgb, m_out);
            end
            if (rgb == 6'h2A) hit++;
        end
        vectors++;
        if (hit != VA * DIV) begin
            miscompares++;
            $display("FAIL single_pixel_clks: got %0d clks of 2A, want %0d", hit, VA * DIV);
        end
    endtask

    task automatic test_full_draw();
        int unsigned hit = 0;
        draw = 1'b1;
        data = 6'h3F;
        wait_frame_align();
        for (int i = 0; i < int'(FRAME * DIV); i++) begin
            @(negedge clk);
            vectors++;
            if ({hsync, vsync, rgb} !== m_out) begin
                miscompares++;
                $display("FAIL full_draw c=%0d: got hs=%b vs=%b rgb=%h, want %h", m_c, hsync, vsync, rgb, m_out);
            end
            if (m_c % DIV == 0 && rgb == 6'h3F) hit++;
        end
        vectors++;
        if (hit != HA * VA) begin
            miscompares++;
            $display("FAIL full_draw_pixels: got %0d, want %0d", hit, HA * VA);
        end
    endtask

    task automatic test_offtick_toggle();
        for (int i = 0; i < int'(FRAME * DIV); i++) begin
            if (m_c % DIV == DIV - 1) begin
                draw = 1'($urandom);
                data = 6'($urandom);
            end else begin
                draw = ~draw;
                data = ~data;
            end
            @(negedge clk);
            vectors++;
            if ({hsync, vsync, rgb} !== m_out) begin
                miscompares++;
                $display("FAIL offtick c=%0d: got hs=%b vs=%b rgb=%h, want %h", m_c, hsync, vsync, rgb, m_out);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic found = 1'b0;
        logic [21:0] t;
        draw = 1'b1;
        data = 6'h0C;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            t = exp_timing(m_c);
            found = (t[21:12] == 10'd5) && (t[11:2] == 10'd2);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL mid_reset_search: got found=%b, want 1", found);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({px, py, pix_tick, frame_start, rgb, hsync, vsync} !== {10'd0, 10'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_reset: got px=%0d py=%0d tick=%b fs=%b rgb=%h hs=%b vs=%b, want reset values",
                     px, py, pix_tick, frame_start, rgb, hsync, vsync);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({px, py} !== {10'd1, 10'd0}) begin
            miscompares++;
            $display("FAIL post_reset_first_tick: got px=%0d py=%0d, want px=1 py=0", px, py);
        end
        for (int i = 0; i < 60; i++) begin
            data = 6'($urandom);
            @(negedge clk);
            vectors++;
            if ({px, py, pix_tick, frame_start, hsync, vsync, rgb} !== {exp_timing(m_c), m_out}) begin
                miscompares++;
                $display("FAIL post_reset c=%0d: got px=%0d py=%0d tick=%b fs=%b out=%h, want %h %h",
                         m_c, px, py, pix_tick, frame_start, {hsync, vsync, rgb}, exp_timing(m_c), m_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_background();
        test_single_pixel();
        test_full_draw();
        test_offtick_toggle();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
